uart_time_set_rx: RTL and testbench

Serial time-setting receiver for the digital clock. It deserialises 8N1 UART bytes arriving on the board's direct serial pin `rxd` and parses the ASCII command `T` `H` `H` `M` `M` `S` `S` `<CR>`. When a complete command is valid, it presents the time as six BCD digits with a one-cycle load strobe. The block is the input-side counterpart to the clock's display path: it sits in the top level between `rxd` and the digital clock's preset inputs.

---
 rtl/uart_pkg.sv | 47 ++++
 rtl/uart_time_set_rx_if.sv | 26 ++
 rtl/uart_rx_byte.sv | 117 +++++++++++
 rtl/uart_time_set_rx.sv | 110 +++++++++++
 tb/tb_uart_time_set_rx.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared constants, state encodings and baud helpers for the serial
// time-setting receiver.
package uart_pkg;

  localparam logic [7:0] CH_T  = 8'h54;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_0  = 8'h30;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  // D0..D5 are consecutive so the digit position is state - PS_D0.
  typedef enum logic [2:0] {
    PS_WAIT_T,
    PS_D0,
    PS_D1,
    PS_D2,
    PS_D3,
    PS_D4,
    PS_D5,
    PS_WAIT_CR
  } ps_state_t;

  function automatic int unsigned calc_div(int unsigned clk_hz, int unsigned baud);
    return clk_hz / baud;
  endfunction

  function automatic int unsigned calc_half(int unsigned clk_hz, int unsigned baud);
    return calc_div(clk_hz, baud) / 2;
  endfunction

  // Largest value accepted at digit position pos (0 = hour tens).
  function automatic logic [3:0] digit_limit(logic [2:0] pos, logic [3:0] hour_tens);
    case (pos)
      3'd0:       return 4'd2;
      3'd1:       return (hour_tens == 4'd2) ? 4'd3 : 4'd9;
      3'd2, 3'd4: return 4'd5;
      default:    return 4'd9;
    endcase
  endfunction

endpackage

// File: rtl/uart_time_set_rx_if.sv
// Serial line input and time/status outputs of the time-setting receiver.
interface uart_time_set_rx_if;
  logic       rxd;
  logic       set_valid;
  logic [3:0] hour_h;
  logic [3:0] hour_l;
  logic [3:0] min_h;
  logic [3:0] min_l;
  logic [3:0] sec_h;
  logic [3:0] sec_l;
  logic       frame_err;
  logic       cmd_err;
  logic       busy;

  modport master (
    output rxd,
    input  set_valid, hour_h, hour_l, min_h, min_l, sec_h, sec_l,
    input  frame_err, cmd_err, busy
  );

  modport slave (
    input  rxd,
    output set_valid, hour_h, hour_l, min_h, min_l, sec_h, sec_l,
    output frame_err, cmd_err, busy
  );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF synchroniser, mid-bit sampling, stop-bit check.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       rxd,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned DIV  = calc_div(CLK_HZ, BAUD);
  localparam int unsigned HALF = calc_half(CLK_HZ, BAUD);
  localparam int unsigned CW   = $clog2(DIV);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

  logic [1:0]    sync_q;
  logic          rx_s;
  rx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  assign rx_s = sync_q[1];

  // Two-stage synchroniser, idles high.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) sync_q <= '1;
    else      sync_q <= {sync_q[0], rxd};
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state: half-bit start check, then one sample per bit period.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == DIV_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == DIV_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            valid_d = 1'b1;
            state_d = RX_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s) state_d = RX_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = RX_IDLE;
      end
    endcase
  end

  // The shift register is untouched until the next start bit is confirmed,
  // so it still holds the byte while byte_valid is high.
  assign byte_data  = shift_q;
  assign byte_valid = valid_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != RX_IDLE);

endmodule

// File: rtl/uart_time_set_rx.sv
// Parses "T HH MM SS <CR>" from the serial line and presents BCD time
// with a one-cycle load strobe.
module uart_time_set_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 115200
) (
  input logic              clk,
  input logic              clr,
  uart_time_set_rx_if.slave bus
);

  logic [7:0]      byte_data;
  logic            byte_valid;
  logic            frame_err;
  logic            busy;

  ps_state_t       state_q, state_d;
  logic [5:0][3:0] shadow_q, shadow_d;
  logic [5:0][3:0] digits_q, digits_d;
  logic            set_valid_q, set_valid_d;
  logic            cmd_err_q, cmd_err_d;
  logic            is_digit;
  logic [2:0]      pos;
  logic [3:0]      limit;
  ps_state_t       recover_state;

  uart_rx_byte #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) u_rx (
    .clk       (clk),
    .clr       (clr),
    .rxd       (bus.rxd),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  // Parser state, shadow digits and output registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= PS_WAIT_T;
      shadow_q    <= '0;
      digits_q    <= '0;
      set_valid_q <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      digits_q    <= digits_d;
      set_valid_q <= set_valid_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  // Command grammar; a rejected byte is re-evaluated as if in WAIT_T.
  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    digits_d      = digits_q;
    set_valid_d   = 1'b0;
    cmd_err_d     = 1'b0;
    // ASCII '0'..'9' carry their value in the low nibble.
    is_digit      = (byte_data[7:4] == CH_0[7:4]) && (byte_data[3:0] <= 4'd9);
    pos           = state_q - PS_D0;
    limit         = digit_limit(pos, shadow_q[0]);
    recover_state = (byte_data == CH_T) ? PS_D0 : PS_WAIT_T;
    if (byte_valid) begin
      case (state_q)
        PS_WAIT_T: begin
          if (byte_data == CH_T) state_d = PS_D0;
        end
        PS_WAIT_CR: begin
          if (byte_data == CH_CR) begin
            digits_d    = shadow_q;
            set_valid_d = 1'b1;
            state_d     = PS_WAIT_T;
          end else begin
            cmd_err_d = 1'b1;
            state_d   = recover_state;
          end
        end
        default: begin
          if (is_digit && (byte_data[3:0] <= limit)) begin
            shadow_d[pos] = byte_data[3:0];
            state_d       = ps_state_t'(state_q + 3'd1);
          end else begin
            cmd_err_d = 1'b1;
            state_d   = recover_state;
          end
        end
      endcase
    end
  end

  assign bus.set_valid = set_valid_q;
  assign bus.cmd_err   = cmd_err_q;
  assign bus.frame_err = frame_err;
  assign bus.busy      = busy;
  assign bus.hour_h    = digits_q[0];
  assign bus.hour_l    = digits_q[1];
  assign bus.min_h     = digits_q[2];
  assign bus.min_l     = digits_q[3];
  assign bus.sec_h     = digits_q[4];
  assign bus.sec_l     = digits_q[5];

endmodule

// File: tb/tb_uart_time_set_rx.sv
// Self-checking bench: a reference parser model pushes expected events
// (with their due cycle) into a queue; a monitor pops and compares them.
module tb_uart_time_set_rx;

  localparam int unsigned CLK_HZ = 5_000_000;
  localparam int unsigned BAUD   = 115200;
  localparam int DIV  = CLK_HZ / BAUD;   // 43
  localparam int HALF = DIV / 2;         // 21

  localparam int K_VALID = 0;
  localparam int K_CMD   = 1;
  localparam int K_FRAME = 2;

  typedef struct {
    int          kind;
    logic [23:0] digits;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  int         mst;
  logic [3:0] msh [6];
  logic [3:0] mout[6];

  uart_time_set_rx_if bus();

  uart_time_set_rx #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] dut_digits();
    return {bus.hour_h, bus.hour_l, bus.min_h, bus.min_l, bus.sec_h, bus.sec_l};
  endfunction

  function automatic logic [23:0] model_digits();
    return {mout[0], mout[1], mout[2], mout[3], mout[4], mout[5]};
  endfunction

  task automatic model_reset();
    mst = 0;
    for (int i = 0; i < 6; i++) begin
      msh[i]  = 4'd0;
      mout[i] = 4'd0;
    end
  endtask

  task automatic push_exp(input int kind, input int due);
    exp_t e;
    e.kind   = kind;
    e.digits = model_digits();
    e.cyc    = due;
    exp_q.push_back(e);
  endtask

  // Reference parser. sc is the cycle the start bit was driven; events are
  // due 2 sync cycles + HALF + 9*DIV + 1 (strobe) + 1 (parser) later.
  task automatic model_byte(input logic [7:0] b, input bit stop_ok, input int sc, input bit timed);
    int lim[6] = '{2, 9, 5, 9, 5, 9};
    int base;
    int p;
    int l;
    base = sc + 2 + HALF + 9 * DIV;
    if (!stop_ok) begin
      push_exp(K_FRAME, timed ? base + 1 : -1);
      return;
    end
    if (mst == 0) begin
      if (b == 8'h54) mst = 1;
    end else if (mst == 7) begin
      if (b == 8'h0D) begin
        for (int i = 0; i < 6; i++) mout[i] = msh[i];
        mst = 0;
        push_exp(K_VALID, timed ? base + 2 : -1);
      end else begin
        mst = (b == 8'h54) ? 1 : 0;
        push_exp(K_CMD, timed ? base + 2 : -1);
      end
    end else begin
      p = mst - 1;
      l = lim[p];
      if (p == 1 && msh[0] == 4'd2) l = 3;
      if (b >= 8'h30 && b <= 8'h39 && int'(b) - 48 <= l) begin
        msh[p] = 4'(b - 8'h30);
        mst    = mst + 1;
      end else begin
        mst = (b == 8'h54) ? 1 : 0;
        push_exp(K_CMD, timed ? base + 2 : -1);
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int period);
    int sc;
    @(posedge clk);
    #1;
    sc = cyc;
    bus.rxd = 1'b0;
    model_byte(b, stop_ok, sc, period == DIV);
    for (int i = 0; i < 8; i++) begin
      repeat (period) @(posedge clk);
      #1 bus.rxd = b[i];
    end
    repeat (period) @(posedge clk);
    #1 bus.rxd = stop_ok;
    repeat (period) @(posedge clk);
    if (!stop_ok) begin
      #1 bus.rxd = 1'b1;
      repeat (2 * DIV) @(posedge clk);
    end
  endtask

  task automatic send_str(input string s, input bit add_cr, input int bad, input int period);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], i != bad, period);
    if (add_cr) send_byte(8'h0D, 1'b1, period);
  endtask

  task automatic settle(input string name);
    repeat (DIV) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s pending: got %0d outstanding events, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Event monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (clr && (bus.set_valid || bus.cmd_err || bus.frame_err)) begin
      int   k;
      exp_t e;
      k = bus.set_valid ? K_VALID : (bus.cmd_err ? K_CMD : K_FRAME);
      checks++;
      if (bus.set_valid && bus.cmd_err) begin
        errors++;
        $display("FAIL excl: set_valid and cmd_err both high at cycle %0d", cyc);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected: kind %0d at cycle %0d, none expected", k, cyc);
      end else begin
        e = exp_q.pop_front();
        if (k !== e.kind) begin
          errors++;
          $display("FAIL kind: got %0d want %0d at cycle %0d", k, e.kind, cyc);
        end
        if (e.cyc >= 0) begin
          checks++;
          if (cyc !== e.cyc) begin
            errors++;
            $display("FAIL timing: kind %0d got cycle %0d want %0d", k, cyc, e.cyc);
          end
        end
        checks++;
        if (dut_digits() !== e.digits) begin
          errors++;
          $display("FAIL digits: got %h want %h at cycle %0d", dut_digits(), e.digits, cyc);
        end
      end
    end
  end

  task automatic test_reset();
    clr = 1'b0;
    bus.rxd = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.set_valid, bus.cmd_err, bus.frame_err, bus.busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000",
               {bus.set_valid, bus.cmd_err, bus.frame_err, bus.busy});
    end
    checks++;
    if (dut_digits() !== 24'h0) begin
      errors++;
      $display("FAIL reset_digits: got %h want 000000", dut_digits());
    end
    clr = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_basic();
    send_str("T123456", 1'b1, -1, DIV);
    settle("basic");
    checks++;
    if (dut_digits() !== 24'h123456) begin
      errors++;
      $display("FAIL basic_digits: got %h want 123456", dut_digits());
    end
  endtask

  task automatic test_range();
    send_str("T235959", 1'b1, -1, DIV);
    send_str("T240000", 1'b1, -1, DIV);
    settle("range");
    checks++;
    if (dut_digits() !== 24'h235959) begin
      errors++;
      $display("FAIL range_digits: got %h want 235959", dut_digits());
    end
  endtask

  task automatic test_restart();
    send_str("T12T081500", 1'b1, -1, DIV);
    settle("restart");
    checks++;
    if (dut_digits() !== 24'h081500) begin
      errors++;
      $display("FAIL restart_digits: got %h want 081500", dut_digits());
    end
  endtask

  // Stop bit of '3' held low: that byte is lost and the parser carries on.
  task automatic test_frame_err();
    send_str("T123456", 1'b1, 3, DIV);
    settle("frame_err");
    checks++;
    if (dut_digits() !== 24'h081500) begin
      errors++;
      $display("FAIL frame_digits: got %h want 081500", dut_digits());
    end
  endtask

  // Longest low pulse that must be rejected: exactly HALF cycles.
  task automatic test_glitch();
    @(posedge clk);
    #1 bus.rxd = 1'b0;
    repeat (HALF) @(posedge clk);
    #1 bus.rxd = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL glitch_busy_hi: got %b want 1 at start check", bus.busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_busy_lo: got %b want 0 after start check", bus.busy);
    end
    repeat (2 * DIV) @(posedge clk);
    settle("glitch");
  endtask

  task automatic test_baud_tolerance();
    send_str("T195807", 1'b1, -1, DIV + 1);
    settle("baud_slow");
    checks++;
    if (dut_digits() !== 24'h195807) begin
      errors++;
      $display("FAIL baud_slow_digits: got %h want 195807", dut_digits());
    end
    send_str("T010203", 1'b1, -1, DIV - 1);
    settle("baud_fast");
    checks++;
    if (dut_digits() !== 24'h010203) begin
      errors++;
      $display("FAIL baud_fast_digits: got %h want 010203", dut_digits());
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] cr;
    cr = 8'h0D;
    send_str("T123456", 1'b0, -1, DIV);
    @(posedge clk);
    #1 bus.rxd = 1'b0;
    for (int i = 0; i < 5; i++) begin
      repeat (DIV) @(posedge clk);
      #1 bus.rxd = cr[i];
    end
    repeat (DIV / 2) @(posedge clk);
    #1 clr = 1'b0;
    #1;
    checks++;
    if (dut_digits() !== 24'h0) begin
      errors++;
      $display("FAIL midreset_digits: got %h want 000000", dut_digits());
    end
    checks++;
    if ({bus.set_valid, bus.cmd_err, bus.frame_err, bus.busy} !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_flags: got %b want 0000",
               {bus.set_valid, bus.cmd_err, bus.frame_err, bus.busy});
    end
    bus.rxd = 1'b1;
    model_reset();
    repeat (5) @(posedge clk);
    #1 clr = 1'b1;
    repeat (12 * DIV) @(posedge clk);
    settle("midreset");
    checks++;
    if (dut_digits() !== 24'h0) begin
      errors++;
      $display("FAIL midreset_hold: got %h want 000000", dut_digits());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_range();
    test_restart();
    test_frame_err();
    test_glitch();
    test_baud_tolerance();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    errors++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
